// File: rtl/digit_scan.sv
// digit_scan: time-multiplexes two 7-segment patterns onto one shared segment
// bus with per-digit enables, blank gaps between slots, optional leading-zero
// blanking of digit 2 and a one-cycle frame strobe at the start of each scan.
module digit_scan #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] segi_1,
    input  logic [6:0] segi_2,
    input  logic       blank_zero,
    output logic [6:0] seg_out,
    output logic [1:0] dig_en,
    output logic       frame_tick
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam bit HAS_GAP = (BLANK_CYCLES > 0);
    localparam logic [CW-1:0] R_LOAD = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] B_LOAD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [6:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] DIG_OFF  = DIG_ACTIVE_LOW ? 2'b11 : 2'b00;
    localparam logic [6:0] ZERO_PAT = 7'b0111111;

    typedef enum logic [1:0] {SHOW1, GAP1, SHOW2, GAP2} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    hold_q, hold_d;
    logic          blank_q, blank_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    dig_q, dig_d;
    logic          tick_q, tick_d;

    logic          go1, go2;
    logic [6:0]    lit;
    logic [1:0]    sel;

    // Next-state: count the current slot down, then advance; entering a SHOW
    // slot captures that digit's pattern and reloads the slot length.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        blank_d = blank_q;
        go1     = 1'b0;
        go2     = 1'b0;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            unique case (state_q)
                SHOW1: begin
                    if (HAS_GAP) begin
                        state_d = GAP1;
                        cnt_d   = B_LOAD;
                    end else begin
                        go2 = 1'b1;
                    end
                end
                GAP1: go2 = 1'b1;
                SHOW2: begin
                    if (HAS_GAP) begin
                        state_d = GAP2;
                        cnt_d   = B_LOAD;
                    end else begin
                        go1 = 1'b1;
                    end
                end
                GAP2: go1 = 1'b1;
                default: go1 = 1'b1;
            endcase
        end
        if (go1) begin
            state_d = SHOW1;
            cnt_d   = R_LOAD;
            hold_d  = segi_1;
            blank_d = 1'b0;
        end
        if (go2) begin
            state_d = SHOW2;
            cnt_d   = R_LOAD;
            hold_d  = segi_2;
            blank_d = blank_zero && (segi_2 == ZERO_PAT);
        end
    end

    // Output decode from the next state so a captured pattern appears on the
    // same edge that enters its slot; polarity applied only here.
    always_comb begin
        lit = 7'h00;
        sel = 2'b00;
        unique case (state_d)
            SHOW1: begin
                lit = hold_d;
                sel = 2'b01;
            end
            SHOW2: begin
                lit = blank_d ? 7'h00 : hold_d;
                sel = 2'b10;
            end
            default: begin
                lit = 7'h00;
                sel = 2'b00;
            end
        endcase
        seg_d  = SEG_ACTIVE_LOW ? ~lit : lit;
        dig_d  = DIG_ACTIVE_LOW ? ~sel : sel;
        tick_d = go1;
    end

    // State, counter, captured pattern and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= GAP2;
            cnt_q   <= '0;
            hold_q  <= 7'h00;
            blank_q <= 1'b0;
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            blank_q <= blank_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            tick_q  <= tick_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_en     = dig_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_digit_scan.sv
// Bench for digit_scan: two instances (with and without blank gaps) share the
// stimulus; a frame-position model predicts every output each cycle, and a
// directed prologue pins the model with hand-computed literal values.
module tb_digit_scan;

    localparam int R = 4;
    localparam int B[2] = '{2, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] segi_1 = 7'h00;
    logic [6:0] segi_2 = 7'h00;
    logic       blank_zero = 1'b0;
    logic [6:0] seg_a, seg_b;
    logic [1:0] dig_a, dig_b;
    logic       ft_a, ft_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    digit_scan #(.REFRESH_DIV(R), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .segi_1(segi_1), .segi_2(segi_2), .blank_zero(blank_zero),
        .seg_out(seg_a), .dig_en(dig_a), .frame_tick(ft_a));

    digit_scan #(.REFRESH_DIV(R), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut0 (
        .clk(clk), .rst(rst), .segi_1(segi_1), .segi_2(segi_2), .blank_zero(blank_zero),
        .seg_out(seg_b), .dig_en(dig_b), .frame_tick(ft_b));

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    // Reference model: position within the scan frame decides everything.
    bit         vld = 1'b0;
    int         t_m[2];
    logic [6:0] hold_m[2];
    bit         blk_m[2];
    logic [6:0] seg_e[2];
    logic [1:0] dig_e[2];
    logic       ft_e[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                t_m[i]   = -1;
                seg_e[i] = 7'h7F;
                dig_e[i] = 2'b11;
                ft_e[i]  = 1'b0;
                vld      = 1'b1;
            end else if (vld) begin
                int p, pos;
                logic [6:0] lit;
                t_m[i] = t_m[i] + 1;
                p   = 2 * (R + B[i]);
                pos = t_m[i] % p;
                lit = 7'h00;
                dig_e[i] = 2'b11;
                if (pos == 0) hold_m[i] = segi_1;
                if (pos == R + B[i]) begin
                    hold_m[i] = segi_2;
                    blk_m[i]  = blank_zero && (segi_2 == 7'b0111111);
                end
                if (pos < R) begin
                    lit = hold_m[i];
                    dig_e[i] = 2'b10;
                end else if (pos >= R + B[i] && pos < 2 * R + B[i]) begin
                    lit = blk_m[i] ? 7'h00 : hold_m[i];
                    dig_e[i] = 2'b01;
                end
                seg_e[i] = ~lit;
                ft_e[i]  = (pos == 0);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (vld) begin
            chk("seg_a", seg_a, seg_e[0]);
            chk("dig_a", {5'd0, dig_a}, {5'd0, dig_e[0]});
            chk("ft_a", {6'd0, ft_a}, {6'd0, ft_e[0]});
            chk("seg_b", seg_b, seg_e[1]);
            chk("dig_b", {5'd0, dig_b}, {5'd0, dig_e[1]});
            chk("ft_b", {6'd0, ft_b}, {6'd0, ft_e[1]});
            chk("bbm_a", {6'd0, dig_a == 2'b00}, 7'd0);
            chk("bbm_b", {6'd0, dig_b == 2'b00}, 7'd0);
        end
    end

    initial begin
        // Reset held for 5 cycles.
        segi_1 = 7'b0000110;
        segi_2 = 7'b1011011;
        repeat (5) begin
            @(negedge clk);
            chk("rst_seg", seg_a, 7'h7F);
            chk("rst_dig", {5'd0, dig_a}, 7'b0000011);
            chk("rst_ft", {6'd0, ft_a}, 7'd0);
        end
        rst = 1'b1;
        // k counts cycles since SHOW1 entry after release.
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (k < 4) begin
                chk("s1_seg", seg_a, 7'b1111001);
                chk("s1_dig", {5'd0, dig_a}, 7'b0000010);
                chk("s1_ft", {6'd0, ft_a}, (k == 0) ? 7'd1 : 7'd0);
            end else if (k < 6) begin
                chk("g1_seg", seg_a, 7'h7F);
                chk("g1_dig", {5'd0, dig_a}, 7'b0000011);
            end else if (k < 10) begin
                chk("s2_seg", seg_a, 7'b0100100);
                chk("s2_dig", {5'd0, dig_a}, 7'b0000001);
            end else if (k < 12) begin
                chk("g2_seg", seg_a, 7'h7F);
            end
            if (k == 12) begin
                chk("f2_ft", {6'd0, ft_a}, 7'd1);
                chk("f2_seg", seg_a, 7'b0000000);
                chk("f2_dig", {5'd0, dig_a}, 7'b0000010);
            end
            if (k == 0 || k == 8) chk("b0_ft", {6'd0, ft_b}, 7'd1);
            if (k == 4) chk("b0_dig", {5'd0, dig_b}, 7'b0000001);
            if (k >= 18 && k < 22) begin
                chk("bz_seg", seg_a, 7'h7F);
                chk("bz_dig", {5'd0, dig_a}, 7'b0000001);
            end
            if (k >= 30 && k < 34) chk("nz_seg", seg_a, 7'b1000000);
            // Stimulus changes after this cycle's checks.
            if (k == 1)  segi_1 = 7'b1111111;
            if (k == 12) begin
                segi_2 = 7'b0111111;
                blank_zero = 1'b1;
            end
            if (k == 19) blank_zero = 1'b0;
            if (k == 44) rst = 1'b0;
        end
        @(negedge clk);
        chk("mid_rst_seg", seg_a, 7'h7F);
        chk("mid_rst_dig", {5'd0, dig_a}, 7'b0000011);
        chk("mid_rst_ft", {6'd0, ft_a}, 7'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("restart_ft", {6'd0, ft_a}, 7'd1);
        chk("restart_seg", seg_a, 7'b0000000);
        // Randomized run with occasional resets.
        for (int n = 0; n < 600; n++) begin
            segi_1 = 7'($urandom);
            segi_2 = ($urandom_range(0, 3) == 0) ? 7'b0111111 : 7'($urandom);
            blank_zero = 1'($urandom);
            rst = ($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
